// File: rtl/quad_enc_decoder.sv
// Quadrature encoder front end. It synchronises the A/B lines, applies a glitch filter to
// each channel, decodes the Gray sequence, and keeps a signed position count.
module quad_enc_decoder #(
  parameter int unsigned FILT_LEN = 4,
  parameter int unsigned CNT_W    = 16,
  parameter bit          X4       = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a,
  input  logic             b,
  input  logic             clr,
  output logic             step_cw,
  output logic             step_ccw,
  output logic             dir,
  output logic             err,
  output logic [CNT_W-1:0] pos
);

  localparam int unsigned       FCNT_W   = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam logic [FCNT_W-1:0] FCNT_MAX = FCNT_W'(FILT_LEN - 1);
  localparam logic signed [3:0] Q_FULL   = 4'sd4;
  localparam logic signed [3:0] Q_NFULL  = -4'sd4;
  localparam logic [1:0]        ST_00    = 2'b00;
  localparam logic [1:0]        ST_10    = 2'b10;
  localparam logic [1:0]        ST_11    = 2'b11;
  localparam logic [1:0]        ST_01    = 2'b01;

  logic              a_s1_q, a_s2_q, b_s1_q, b_s2_q;
  logic              filt_a_q, filt_a_d, filt_b_q, filt_b_d;
  logic [FCNT_W-1:0] cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
  logic [1:0]        prev_q;
  logic signed [3:0] q_q, q_d;
  logic              step_cw_q, step_cw_d, step_ccw_q, step_ccw_d;
  logic              dir_q, dir_d, err_q, err_d;
  logic [CNT_W-1:0]  pos_q, pos_d;

  logic [1:0]        cur_st;
  logic              quarter_up, quarter_dn, illegal;
  logic signed [3:0] q_inc, q_dec;

  assign step_cw  = step_cw_q;
  assign step_ccw = step_ccw_q;
  assign dir      = dir_q;
  assign err      = err_q;
  assign pos      = pos_q;

  // State that follows one cw quarter: 00 -> 10 -> 11 -> 01 -> 00
  function automatic logic [1:0] cw_next(input logic [1:0] s);
    case (s)
      ST_00:   cw_next = ST_10;
      ST_10:   cw_next = ST_11;
      ST_11:   cw_next = ST_01;
      default: cw_next = ST_00;
    endcase
  endfunction

  // State that follows one ccw quarter: 00 -> 01 -> 11 -> 10 -> 00
  function automatic logic [1:0] ccw_next(input logic [1:0] s);
    case (s)
      ST_00:   ccw_next = ST_01;
      ST_01:   ccw_next = ST_11;
      ST_11:   ccw_next = ST_10;
      default: ccw_next = ST_00;
    endcase
  endfunction

  // Per-channel filter: the output follows s2 only after FILT_LEN consecutive differing samples
  always_comb begin
    filt_a_d = filt_a_q;
    cnt_a_d  = cnt_a_q;
    filt_b_d = filt_b_q;
    cnt_b_d  = cnt_b_q;
    if (a_s2_q == filt_a_q) begin
      cnt_a_d = '0;
    end else if (cnt_a_q == FCNT_MAX) begin
      filt_a_d = a_s2_q;
      cnt_a_d  = '0;
    end else begin
      cnt_a_d = cnt_a_q + FCNT_W'(1);
    end
    if (b_s2_q == filt_b_q) begin
      cnt_b_d = '0;
    end else if (cnt_b_q == FCNT_MAX) begin
      filt_b_d = b_s2_q;
      cnt_b_d  = '0;
    end else begin
      cnt_b_d = cnt_b_q + FCNT_W'(1);
    end
  end

  assign cur_st     = {filt_a_q, filt_b_q};
  assign quarter_up = (cur_st == cw_next(prev_q));
  assign quarter_dn = (cur_st == ccw_next(prev_q));
  assign illegal    = (cur_st == ~prev_q);
  assign q_inc      = q_q + 4'sd1;
  assign q_dec      = q_q - 4'sd1;

  // Gray decode, sub-step accumulation (x1), and position update
  always_comb begin
    q_d        = q_q;
    step_cw_d  = 1'b0;
    step_ccw_d = 1'b0;
    err_d      = illegal;
    dir_d      = dir_q;
    pos_d      = pos_q;
    if (illegal) begin
      q_d = 4'sd0;
    end else if (quarter_up) begin
      if (X4) begin
        step_cw_d = 1'b1;
      end else if (cur_st == ST_00) begin
        step_cw_d = (q_inc == Q_FULL);
        q_d       = 4'sd0;
      end else begin
        q_d = q_inc;
      end
    end else if (quarter_dn) begin
      if (X4) begin
        step_ccw_d = 1'b1;
      end else if (cur_st == ST_00) begin
        step_ccw_d = (q_dec == Q_NFULL);
        q_d        = 4'sd0;
      end else begin
        q_d = q_dec;
      end
    end
    if (step_cw_d) begin
      dir_d = 1'b0;
      pos_d = pos_q + CNT_W'(1);
    end else if (step_ccw_d) begin
      dir_d = 1'b1;
      pos_d = pos_q - CNT_W'(1);
    end
    // Clear overrides the count update, but the step pulses and dir still report the step
    if (clr) begin
      pos_d = '0;
      q_d   = 4'sd0;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_s1_q     <= 1'b0;
      a_s2_q     <= 1'b0;
      b_s1_q     <= 1'b0;
      b_s2_q     <= 1'b0;
      filt_a_q   <= 1'b0;
      filt_b_q   <= 1'b0;
      cnt_a_q    <= '0;
      cnt_b_q    <= '0;
      prev_q     <= ST_00;
      q_q        <= 4'sd0;
      step_cw_q  <= 1'b0;
      step_ccw_q <= 1'b0;
      dir_q      <= 1'b0;
      err_q      <= 1'b0;
      pos_q      <= '0;
    end else begin
      a_s1_q     <= a;
      a_s2_q     <= a_s1_q;
      b_s1_q     <= b;
      b_s2_q     <= b_s1_q;
      filt_a_q   <= filt_a_d;
      filt_b_q   <= filt_b_d;
      cnt_a_q    <= cnt_a_d;
      cnt_b_q    <= cnt_b_d;
      prev_q     <= cur_st;
      q_q        <= q_d;
      step_cw_q  <= step_cw_d;
      step_ccw_q <= step_ccw_d;
      dir_q      <= dir_d;
      err_q      <= err_d;
      pos_q      <= pos_d;
    end
  end

endmodule

// File: tb/tb_quad_enc_decoder.sv
// Bench for quad_enc_decoder. Three instances share the same inputs: x1/16-bit, x4/16-bit,
// and x1/4-bit. A per-cycle reference model is computed from the quadrature rules.
module tb_quad_enc_decoder;

  localparam int FL = 4;

  logic clk, rst_n, a, b, clr;
  logic cw0, ccw0, dir0, err0, cw1, ccw1, dir1, err1, cw2, ccw2, dir2, err2;
  logic [15:0] pos0, pos1;
  logic [3:0]  pos2;

  int checks = 0;
  int errors = 0;

  quad_enc_decoder #(.FILT_LEN(FL), .CNT_W(16), .X4(1'b0)) u_x1 (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .clr(clr),
    .step_cw(cw0), .step_ccw(ccw0), .dir(dir0), .err(err0), .pos(pos0));
  quad_enc_decoder #(.FILT_LEN(FL), .CNT_W(16), .X4(1'b1)) u_x4 (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .clr(clr),
    .step_cw(cw1), .step_ccw(ccw1), .dir(dir1), .err(err1), .pos(pos1));
  quad_enc_decoder #(.FILT_LEN(FL), .CNT_W(4), .X4(1'b0)) u_w4 (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .clr(clr),
    .step_cw(cw2), .step_ccw(ccw2), .dir(dir2), .err(err2), .pos(pos2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  bit       m_s1a, m_s2a, m_s1b, m_s2b;
  bit [1:0] m_s, m_p;
  bit       m_wa[$];
  bit       m_wb[$];
  int       m_q[3];
  int       m_pos[3];
  bit       m_dir[3], m_cw[3], m_ccw[3];
  bit       m_err;

  // The index of a state along the cw cycle
  function automatic int idx(input bit [1:0] s);
    case (s)
      2'b00:   return 0;
      2'b10:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  task automatic model_reset();
    m_s1a = 0; m_s2a = 0; m_s1b = 0; m_s2b = 0;
    m_s = 2'b00; m_p = 2'b00;
    m_wa.delete(); m_wb.delete();
    m_err = 0;
    for (int k = 0; k < 3; k++) begin
      m_q[k] = 0; m_pos[k] = 0; m_dir[k] = 0; m_cw[k] = 0; m_ccw[k] = 0;
    end
  endtask

  // Advance the model by one rising clock edge, using the inputs present at that edge
  task automatic model_edge();
    int d, st;
    bit na, nb, alla, allb;
    if (!rst_n) begin
      model_reset();
      return;
    end
    d = (idx(m_s) - idx(m_p)) & 3;
    m_err = (d == 2);
    for (int k = 0; k < 3; k++) begin
      st = 0; m_cw[k] = 0; m_ccw[k] = 0;
      if (d == 2) m_q[k] = 0;
      else if (d != 0) begin
        if (k == 1) st = (d == 1) ? 1 : -1;
        else begin
          m_q[k] += (d == 1) ? 1 : -1;
          if (m_s == 2'b00) begin
            if (m_q[k] == 4) st = 1;
            else if (m_q[k] == -4) st = -1;
            m_q[k] = 0;
          end
        end
      end
      if (st != 0) begin
        m_cw[k] = (st > 0); m_ccw[k] = (st < 0); m_dir[k] = (st < 0);
        m_pos[k] += st;
      end
      if (clr) begin m_pos[k] = 0; m_q[k] = 0; end
      m_pos[k] = m_pos[k] & ((k == 2) ? 32'hF : 32'hFFFF);
    end
    // The filtered value flips only when the last FL synchronised samples all disagree with it
    m_wa.push_back(m_s2a); if (m_wa.size() > FL) void'(m_wa.pop_front());
    m_wb.push_back(m_s2b); if (m_wb.size() > FL) void'(m_wb.pop_front());
    alla = (m_wa.size() == FL); allb = (m_wb.size() == FL);
    foreach (m_wa[i]) if (m_wa[i] == m_s[1]) alla = 0;
    foreach (m_wb[i]) if (m_wb[i] == m_s[0]) allb = 0;
    na = alla ? ~m_s[1] : m_s[1];
    nb = allb ? ~m_s[0] : m_s[0];
    m_p = m_s; m_s = {na, nb};
    m_s2a = m_s1a; m_s1a = a; m_s2b = m_s1b; m_s1b = b;
  endtask

  function automatic logic [47:0] exp_vec();
    return {m_cw[0], m_ccw[0], m_dir[0], m_err, 16'(m_pos[0]),
            m_cw[1], m_ccw[1], m_dir[1], m_err, 16'(m_pos[1]),
            m_cw[2], m_ccw[2], m_dir[2], m_err, 4'(m_pos[2])};
  endfunction

  function automatic logic [47:0] get_obs();
    return {cw0, ccw0, dir0, err0, pos0, cw1, ccw1, dir1, err1, pos1, cw2, ccw2, dir2, err2, pos2};
  endfunction

  // ---------------- stimulus helpers ----------------
  typedef struct packed { logic a; logic b; logic c; } stim_t;
  stim_t stim[$];
  logic [1:0] cwseq[4];
  logic [1:0] ccwseq[4];
  logic [47:0] obs;

  task automatic cyc(input logic na, input logic nb, input logic nc, input logic nr);
    @(negedge clk);
    a = na; b = nb; clr = nc; rst_n = nr;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic seg(input logic [1:0] ab, input logic c, input int n);
    for (int i = 0; i < n; i++) stim.push_back({ab[1], ab[0], c});
  endtask

  task automatic seg_cycle(input bit is_cw, input int qlen);
    for (int q = 0; q < 4; q++) seg(is_cw ? cwseq[q] : ccwseq[q], 1'b0, qlen);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    model_reset();
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0);
      checks++;
      if (get_obs() !== 48'h0) begin
        errors++; $display("FAIL reset obs=%h exp=%h", get_obs(), 48'h0);
      end
    end
    cyc(0, 0, 0, 1);
  endtask

  task automatic test_x1_cycle();
    stim.delete();
    seg_cycle(1, 100);
    seg_cycle(0, 100);
    for (int i = 0; i < stim.size(); i++) begin
      cyc(stim[i].a, stim[i].b, stim[i].c, 1'b1);
      obs = get_obs(); checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL x1_cycle i=%0d obs=%h exp=%h", i, obs, exp_vec());
      end
      if (i == 305 || i == 306) begin
        checks++;
        if (cw0 !== (i == 306)) begin
          errors++; $display("FAIL latency i=%0d step_cw=%b exp=%b", i, cw0, (i == 306));
        end
      end
      if (i == 399) begin
        checks++;
        if ({pos0, dir0, pos1} !== {16'd1, 1'b0, 16'd4}) begin
          errors++; $display("FAIL after_cw pos0=%0d dir0=%b pos1=%0d exp 1 0 4", pos0, dir0, pos1);
        end
      end
    end
    checks++;
    if ({pos0, dir0, pos1} !== {16'd0, 1'b1, 16'd0}) begin
      errors++; $display("FAIL after_ccw pos0=%0d dir0=%b pos1=%0d exp 0 1 0", pos0, dir0, pos1);
    end
  endtask

  task automatic test_x4_ten();
    int nerr = 0;
    stim.delete();
    for (int c = 0; c < 10; c++) seg_cycle(1, 20);
    for (int i = 0; i < stim.size(); i++) begin
      cyc(stim[i].a, stim[i].b, stim[i].c, 1'b1);
      obs = get_obs(); checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL x4_ten i=%0d obs=%h exp=%h", i, obs, exp_vec());
      end
      nerr += int'(err0 | err1 | err2);
    end
    checks++;
    if ({pos1, pos0, 32'(nerr)} !== {16'd40, 16'd10, 32'd0}) begin
      errors++; $display("FAIL x4_ten_end pos1=%0d pos0=%0d errs=%0d exp 40 10 0", pos1, pos0, nerr);
    end
  endtask

  task automatic test_bounce();
    int n4 = 0, n1 = 0, nerr = 0, nany = 0;
    stim.delete();
    seg(2'b00, 0, 20);
    for (int g = 0; g < 30; g++) begin seg(2'b10, 0, 3); seg(2'b00, 0, 2); end
    seg(2'b10, 0, 100);
    for (int i = 0; i < stim.size(); i++) begin
      cyc(stim[i].a, stim[i].b, stim[i].c, 1'b1);
      obs = get_obs(); checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL bounce i=%0d obs=%h exp=%h", i, obs, exp_vec());
      end
      n4 += int'(cw1 | ccw1); nerr += int'(err1);
    end
    checks++;
    if (n4 != 1 || nerr != 0) begin
      errors++; $display("FAIL bounce_quarters got=%0d errs=%0d exp 1 0", n4, nerr);
    end
    stim.delete();
    seg(2'b11, 0, 50); seg(2'b01, 0, 50); seg(2'b00, 0, 50);
    seg(2'b01, 0, 3); seg(2'b00, 0, 30);
    for (int i = 0; i < stim.size(); i++) begin
      cyc(stim[i].a, stim[i].b, stim[i].c, 1'b1);
      obs = get_obs(); checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL bounce2 i=%0d obs=%h exp=%h", i, obs, exp_vec());
      end
      if (i < 150) n1 += int'(cw0);
      else nany += int'(cw0 | ccw0 | err0 | cw1 | ccw1 | err1);
    end
    checks++;
    if (n1 != 1 || nany != 0 || pos0 !== 16'd11) begin
      errors++; $display("FAIL bounce_end steps=%0d bglitch=%0d pos0=%0d exp 1 0 11", n1, nany, pos0);
    end
  endtask

  task automatic test_partial();
    stim.delete();
    seg(2'b00, 1, 1);
    for (int r = 0; r < 5; r++) begin seg(2'b00, 0, 20); seg(2'b10, 0, 20); end
    for (int r = 0; r < 5; r++) begin seg(2'b00, 0, 20); seg(2'b01, 0, 20); end
    seg(2'b00, 0, 20);
    for (int i = 0; i < stim.size(); i++) begin
      cyc(stim[i].a, stim[i].b, stim[i].c, 1'b1);
      obs = get_obs(); checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL partial i=%0d obs=%h exp=%h", i, obs, exp_vec());
      end
    end
    checks++;
    if (pos0 !== 16'd0 || pos1 !== 16'd0) begin
      errors++; $display("FAIL partial_end pos0=%0d pos1=%0d exp 0 0", pos0, pos1);
    end
  endtask

  task automatic test_illegal();
    int nerr = 0;
    stim.delete();
    seg(2'b00, 0, 20); seg(2'b11, 0, 30);
    for (int i = 0; i < stim.size(); i++) begin
      cyc(stim[i].a, stim[i].b, stim[i].c, 1'b1);
      obs = get_obs(); checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL illegal i=%0d obs=%h exp=%h", i, obs, exp_vec());
      end
      nerr += int'(err0);
    end
    checks++;
    if (nerr != 1 || pos0 !== 16'd0 || dir0 !== 1'b0) begin
      errors++; $display("FAIL illegal_err errs=%0d pos0=%0d dir0=%b exp 1 0 0", nerr, pos0, dir0);
    end
    stim.delete();
    seg(2'b01, 0, 30); seg(2'b00, 0, 30); seg_cycle(1, 30);
    for (int i = 0; i < stim.size(); i++) begin
      cyc(stim[i].a, stim[i].b, stim[i].c, 1'b1);
      obs = get_obs(); checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL illegal2 i=%0d obs=%h exp=%h", i, obs, exp_vec());
      end
    end
    checks++;
    if (pos0 !== 16'd1) begin
      errors++; $display("FAIL illegal_recover pos0=%0d exp 1", pos0);
    end
  endtask

  task automatic test_wrap_clr_rst();
    stim.delete();
    seg(2'b00, 1, 1);
    for (int c = 0; c < 7; c++) seg_cycle(1, 20);
    for (int i = 0; i < stim.size(); i++) begin
      cyc(stim[i].a, stim[i].b, stim[i].c, 1'b1);
      obs = get_obs(); checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL wrap i=%0d obs=%h exp=%h", i, obs, exp_vec());
      end
    end
    checks++;
    if (pos2 !== 4'd7) begin errors++; $display("FAIL wrap_7 pos2=%0d exp 7", pos2); end
    stim.delete();
    seg_cycle(1, 20);
    for (int i = 0; i < stim.size(); i++) begin
      cyc(stim[i].a, stim[i].b, stim[i].c, 1'b1);
      obs = get_obs(); checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL wrap2 i=%0d obs=%h exp=%h", i, obs, exp_vec());
      end
    end
    checks++;
    if (pos2 !== 4'h8 || pos0 !== 16'd8) begin
      errors++; $display("FAIL wrap_min pos2=%h pos0=%0d exp 8 8", pos2, pos0);
    end
    // A clear lands on the same edge as the step pulse
    stim.delete();
    seg(2'b10, 0, 20); seg(2'b11, 0, 20); seg(2'b01, 0, 20);
    seg(2'b00, 0, 6); seg(2'b00, 1, 1); seg(2'b00, 0, 10);
    for (int i = 0; i < stim.size(); i++) begin
      cyc(stim[i].a, stim[i].b, stim[i].c, 1'b1);
      obs = get_obs(); checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL clr_step i=%0d obs=%h exp=%h", i, obs, exp_vec());
      end
      if (i == 66) begin
        checks++;
        if ({cw0, dir0, pos0, pos2} !== {1'b1, 1'b0, 16'd0, 4'd0}) begin
          errors++; $display("FAIL clr_coincident cw0=%b dir0=%b pos0=%0d pos2=%0d exp 1 0 0 0",
                             cw0, dir0, pos0, pos2);
        end
      end
    end
    // Asynchronous reset while the encoder is mid-cycle at 11
    stim.delete();
    seg(2'b10, 0, 20); seg(2'b11, 0, 20);
    for (int i = 0; i < stim.size(); i++) begin
      cyc(stim[i].a, stim[i].b, stim[i].c, 1'b1);
      obs = get_obs(); checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL pre_rst i=%0d obs=%h exp=%h", i, obs, exp_vec());
      end
    end
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (get_obs() !== 48'h0) begin
      errors++; $display("FAIL async_rst obs=%h exp=%h", get_obs(), 48'h0);
    end
    cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
    stim.delete();
    seg(2'b00, 0, 10); seg_cycle(1, 20);
    for (int i = 0; i < stim.size(); i++) begin
      cyc(stim[i].a, stim[i].b, stim[i].c, 1'b1);
      obs = get_obs(); checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL post_rst i=%0d obs=%h exp=%h", i, obs, exp_vec());
      end
    end
    checks++;
    if (pos0 !== 16'd1 || pos2 !== 4'd1 || pos1 !== 16'd4) begin
      errors++; $display("FAIL post_rst_count pos0=%0d pos2=%0d pos1=%0d exp 1 1 4", pos0, pos2, pos1);
    end
  endtask

  task automatic test_random();
    int cur = 0, r, dwell;
    logic [1:0] ab;
    stim.delete();
    while (stim.size() < 3000) begin
      r = int'($urandom_range(0, 9));
      if (r < 4) cur = (cur + 1) & 3;
      else if (r < 8) cur = (cur + 3) & 3;
      else if (r == 8) cur = (cur + 2) & 3;
      ab = cwseq[(cur + 3) & 3];
      dwell = int'($urandom_range(1, 12));
      for (int j = 0; j < dwell; j++) seg(ab, ($urandom_range(0, 39) == 0), 1);
    end
    for (int i = 0; i < stim.size(); i++) begin
      cyc(stim[i].a, stim[i].b, stim[i].c, 1'b1);
      obs = get_obs(); checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL random i=%0d obs=%h exp=%h", i, obs, exp_vec());
      end
    end
  endtask

  initial begin
    cwseq[0] = 2'b10; cwseq[1] = 2'b11; cwseq[2] = 2'b01; cwseq[3] = 2'b00;
    ccwseq[0] = 2'b01; ccwseq[1] = 2'b11; ccwseq[2] = 2'b10; ccwseq[3] = 2'b00;
    a = 1'b0; b = 1'b0; clr = 1'b0; rst_n = 1'b0;
    test_reset();
    test_x1_cycle();
    test_x4_ten();
    test_bounce();
    test_partial();
    test_illegal();
    test_wrap_clr_rst();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
